// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the core (port 0) and the
// image stream unit (port 1), plus the drain/save/acknowledge sequence for the memory dump.
module data_mem_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 64,
  parameter int SAVE_TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] memAddress,
  output logic [DATA_W-1:0] memInputData,
  output logic              memWriteEnable,
  input  logic [DATA_W-1:0] memOut,
  output logic              memSave,
  input  logic              memDoneSaving,
  input  logic              saveReq,
  output logic              saveAck,
  output logic              saveErr,
  output logic              busy
);

  localparam int CNT_W = $clog2(SAVE_TIMEOUT + 1);

  typedef enum logic [1:0] {ARB, DRAIN, SAVE, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             err_q, err_nxt;
  logic             rr_last;
  logic             gnt0_c, gnt1_c;
  logic             accept, sel;
  logic             rd_pend0, rd_pend1;

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned,
  // which is what keeps this block free of inferred latches.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    err_nxt   = err_q;
    gnt0_c    = 1'b0;
    gnt1_c    = 1'b0;
    case (state)
      ARB: begin
        if (saveReq) begin
          state_nxt = DRAIN;
        end else if (req0 && req1) begin
          gnt0_c = rr_last;
          gnt1_c = !rr_last;
        end else begin
          gnt0_c = req0;
          gnt1_c = req1;
        end
      end
      DRAIN: state_nxt = SAVE;
      SAVE: begin
        if (memDoneSaving) begin
          state_nxt = DONE;
          err_nxt   = 1'b0;
        end else if (cnt == CNT_W'(SAVE_TIMEOUT - 1)) begin
          state_nxt = DONE;
          err_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        state_nxt = ARB;
        cnt_nxt   = '0;
      end
      default: state_nxt = ARB;
    endcase
  end

  // Grants are combinational but must read 0 the instant reset is asserted.
  assign gnt0    = gnt0_c & rst_n;
  assign gnt1    = gnt1_c & rst_n;
  assign accept  = (gnt0_c & req0) | (gnt1_c & req1);
  assign sel     = gnt1_c & req1;
  assign saveAck = (state == DONE);
  assign saveErr = (state == DONE) & err_q;
  assign busy    = (state != ARB);

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ARB;
      cnt     <= '0;
      err_q   <= 1'b0;
      memSave <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      err_q   <= err_nxt;
      memSave <= (state_nxt == SAVE);
    end
  end

  // NOTE: these are pipeline registers rather than a storage array, so they are reset
  // along with everything else and the memory drive is quiet straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last        <= 1'b1;
      memAddress     <= '0;
      memInputData   <= '0;
      memWriteEnable <= 1'b0;
      rd_pend0       <= 1'b0;
      rd_pend1       <= 1'b0;
      rvalid0        <= 1'b0;
      rvalid1        <= 1'b0;
      rdata0         <= '0;
      rdata1         <= '0;
    end else begin
      rvalid0        <= rd_pend0;
      rvalid1        <= rd_pend1;
      if (rd_pend0) rdata0 <= memOut;
      if (rd_pend1) rdata1 <= memOut;
      memWriteEnable <= 1'b0;
      rd_pend0       <= 1'b0;
      rd_pend1       <= 1'b0;
      if (accept) begin
        rr_last        <= sel;
        memAddress     <= sel ? addr1 : addr0;
        memInputData   <= sel ? wdata1 : wdata0;
        memWriteEnable <= sel ? we1 : we0;
        rd_pend0       <= !sel && !we0;
        rd_pend1       <= sel && !we1;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios with literal expectations, then random
// traffic compared every cycle against a transaction-level reference model.
module tb_data_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 64;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0 = 0, req1 = 0, we0 = 0, we1 = 0, saveReq = 0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, memWriteEnable, memSave, memDoneSaving;
  logic          saveAck, saveErr, busy;
  logic [DW-1:0] rdata0, rdata1, memInputData, memOut;
  logic [AW-1:0] memAddress;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 0;

  always #5 clk = ~clk;

  data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .SAVE_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .memAddress(memAddress), .memInputData(memInputData), .memWriteEnable(memWriteEnable),
    .memOut(memOut), .memSave(memSave), .memDoneSaving(memDoneSaving),
    .saveReq(saveReq), .saveAck(saveAck), .saveErr(saveErr), .busy(busy)
  );

  // Environment memory: combinational read, write and save bookkeeping at mid-cycle.
  logic [DW-1:0] bmem [0:255];
  int            done_after = 0;
  int            save_seen = 0;
  logic          done_drv = 1'b0;
  assign memOut        = bmem[memAddress[7:0]];
  assign memDoneSaving = done_drv;

  always @(negedge clk) begin
    if (memWriteEnable === 1'b1) bmem[memAddress[7:0]] = memInputData;
    if (memSave === 1'b1) begin
      done_drv = (done_after != 0) && (save_seen == done_after - 1);
      save_seen++;
    end else begin
      save_seen = 0;
      done_drv  = 1'b0;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 drain, 2 saving, 3 acknowledge.
  logic [DW-1:0] rmem [0:255];
  int            ph, scnt, pref, pend;
  logic          m_err, m_acc0, m_acc1;
  logic          e_we, e_rv0, e_rv1;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_rd0, e_rd1, pend_data;

  function automatic logic [1:0] exp_gnt();
    if (ph != 0 || saveReq) return 2'b00;
    if (req0 && req1) return (pref == 0) ? 2'b01 : 2'b10;
    return {req1, req0};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [1:0]    g;
    int            p;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          w;
    if (!rst_n) begin
      ph = 0; scnt = 0; m_err = 0; pref = 0; pend = -1;
      e_we = 0; e_addr = '0; e_wdata = '0; e_rv0 = 0; e_rv1 = 0; e_rd0 = '0; e_rd1 = '0;
      m_acc0 = 0; m_acc1 = 0; pend_data = '0;
    end else begin
      g = exp_gnt();
      e_rv0 = (pend == 0);
      e_rv1 = (pend == 1);
      if (pend == 0) e_rd0 = pend_data;
      if (pend == 1) e_rd1 = pend_data;
      pend = -1;
      e_we = 0;
      m_acc0 = g[0];
      m_acc1 = g[1];
      if (g != 2'b00) begin
        p = g[1] ? 1 : 0;
        a = p ? addr1 : addr0;
        d = p ? wdata1 : wdata0;
        w = p ? we1 : we0;
        e_addr = a; e_wdata = d; e_we = w;
        if (w) rmem[a[7:0]] = d;
        else begin
          pend = p;
          pend_data = rmem[a[7:0]];
        end
        pref = 1 - p;
      end
      case (ph)
        0: if (saveReq) ph = 1;
        1: begin ph = 2; scnt = 0; end
        2: begin
          if (memDoneSaving) begin ph = 3; m_err = 0; end
          else if (scnt == TO - 1) begin ph = 3; m_err = 1; end
          else scnt++;
        end
        default: ph = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    logic [1:0] g;
    if (cmp_en && rst_n === 1'b1) begin
      g = exp_gnt();
      check("gnt0", 64'(gnt0), 64'(g[0]));
      check("gnt1", 64'(gnt1), 64'(g[1]));
      check("mem_we", 64'(memWriteEnable), 64'(e_we));
      check("mem_addr", 64'(memAddress), 64'(e_addr));
      check("mem_wdata", memInputData, e_wdata);
      check("rvalid0", 64'(rvalid0), 64'(e_rv0));
      check("rvalid1", 64'(rvalid1), 64'(e_rv1));
      check("rdata0", rdata0, e_rd0);
      check("rdata1", rdata1, e_rd1);
      check("mem_save", 64'(memSave), 64'(ph == 2));
      check("save_ack", 64'(saveAck), 64'(ph == 3));
      check("save_err", 64'(saveErr), 64'(ph == 3 && m_err));
      check("busy", 64'(busy), 64'(ph != 0));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // Pulses saveReq from posedge+1 and follows the sequence up to the acknowledge cycle.
  task automatic run_save(input string tag, input int exp_cycles, input logic exp_err);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    saveReq = 1'b1;
    @(negedge clk);
    check($sformatf("%s_no_gnt_on_req", tag), 64'(gnt0 | gnt1), 64'(0));
    step();
    saveReq = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (saveAck) seen = 1;
      else begin
        check($sformatf("%s_busy", tag), 64'(busy), 64'(1));
        check($sformatf("%s_no_gnt", tag), 64'(gnt0 | gnt1), 64'(0));
        if (memSave) n++;
        step();
      end
    end
    check($sformatf("%s_ack_seen", tag), 64'(seen), 64'(1));
    check($sformatf("%s_save_cycles", tag), 64'(n), 64'(exp_cycles));
    check($sformatf("%s_err", tag), 64'(saveErr), 64'(exp_err));
    check($sformatf("%s_save_low", tag), 64'(memSave), 64'(0));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      bmem[i] = {$urandom, $urandom};
      rmem[i] = bmem[i];
    end
    bmem[1] = 64'h1111_1111_1111_1111; rmem[1] = bmem[1];
    bmem[2] = 64'h2222_2222_2222_2222; rmem[2] = bmem[2];

    repeat (2) step();
    check("rst_gnt", 64'({gnt0, gnt1}), 64'(0));
    check("rst_we", 64'(memWriteEnable), 64'(0));
    check("rst_addr", 64'(memAddress), 64'(0));
    check("rst_save", 64'({memSave, saveAck, saveErr, busy}), 64'(0));
    check("rst_rvalid", 64'({rvalid0, rvalid1}), 64'(0));
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // single write then read back
    req0 = 1; we0 = 1; addr0 = 16'h0010; wdata0 = 64'hDEADBEEF_01234567;
    @(negedge clk); check("t1_gnt0", 64'(gnt0), 64'(1));
    step(); req0 = 0; we0 = 0;
    @(negedge clk);
    check("t1_we", 64'(memWriteEnable), 64'(1));
    check("t1_addr", 64'(memAddress), 64'h10);
    check("t1_wdata", memInputData, 64'hDEADBEEF_01234567);
    step(); req0 = 1; we0 = 0; addr0 = 16'h0010;
    @(negedge clk);
    check("t1_we_one_cycle", 64'(memWriteEnable), 64'(0));
    check("t1_rd_gnt0", 64'(gnt0), 64'(1));
    step(); req0 = 0;
    @(negedge clk); check("t1_rvalid_early", 64'(rvalid0), 64'(0));
    step();
    @(negedge clk);
    check("t1_rvalid", 64'(rvalid0), 64'(1));
    check("t1_rdata", rdata0, 64'hDEADBEEF_01234567);
    step();
    @(negedge clk); check("t1_rvalid_pulse", 64'(rvalid0), 64'(0));
    step();

    // contention from a fresh reset: grants alternate starting with port 0
    apply_reset();
    req0 = 1; we0 = 0; addr0 = 16'h0001;
    req1 = 1; we1 = 0; addr1 = 16'h0002;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("t2_gnt0_%0d", i), 64'(gnt0), 64'(i % 2 == 0));
      check($sformatf("t2_gnt1_%0d", i), 64'(gnt1), 64'(i % 2 == 1));
      step();
    end
    req0 = 0; req1 = 0;
    step();
    @(negedge clk);
    check("t2_rdata0", rdata0, 64'h1111_1111_1111_1111);
    check("t2_rdata1", rdata1, 64'h2222_2222_2222_2222);
    step();

    // save with port 1 waiting, memory reports done after 5 cycles
    done_after = 5;
    req1 = 1; we1 = 0; addr1 = 16'h0003;
    run_save("t3", 5, 1'b0);
    check("t3_gnt1_in_done", 64'(gnt1), 64'(0));
    step();
    @(negedge clk);
    check("t3_gnt1_after", 64'(gnt1), 64'(1));
    check("t3_idle", 64'(busy), 64'(0));
    step(); req1 = 0;
    step();

    // save timeout
    done_after = 0;
    run_save("t4", TO, 1'b1);
    step();

    // reset in the middle of a write
    req0 = 1; we0 = 1; addr0 = 16'h0080; wdata0 = 64'h0BAD_F00D_0BAD_F00D;
    step();
    check("t5_we_before", 64'(memWriteEnable), 64'(1));
    we0 = 0; addr0 = 16'h0005; req1 = 1; we1 = 0; addr1 = 16'h0006;
    #1 rst_n = 1'b0;
    #1;
    check("t5_we_cleared", 64'(memWriteEnable), 64'(0));
    check("t5_gnt_cleared", 64'({gnt0, gnt1}), 64'(0));
    check("t5_rvalid_cleared", 64'({rvalid0, rvalid1}), 64'(0));
    check("t5_save_cleared", 64'({memSave, busy}), 64'(0));
    step(); rst_n = 1'b1;
    @(negedge clk);
    check("t5_tie_gnt0", 64'(gnt0), 64'(1));
    check("t5_tie_gnt1", 64'(gnt1), 64'(0));
    step(); req0 = 0;
    step(); req1 = 0;
    step();

    // save request and port 0 request in the same cycle
    done_after = 2;
    req0 = 1; we0 = 0; addr0 = 16'h0007;
    run_save("t6", 2, 1'b0);
    check("t6_gnt0_in_done", 64'(gnt0), 64'(0));
    step();
    @(negedge clk); check("t6_gnt0_after", 64'(gnt0), 64'(1));
    step(); req0 = 0;
    step();

    // reset while saving drops memSave at once
    done_after = 0;
    saveReq = 1; step(); saveReq = 0;
    repeat (3) step();
    check("t7_save_high", 64'(memSave), 64'(1));
    rst_n = 1'b0;
    #1 check("t7_save_cleared", 64'(memSave), 64'(0));
    step(); rst_n = 1'b1;

    // random traffic against the model
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!req0 || m_acc0) begin
        req0 = ($urandom_range(0, 2) != 0);
        we0 = 1'($urandom_range(0, 1));
        addr0 = AW'($urandom_range(0, 31));
        wdata0 = {$urandom, $urandom};
      end
      if (!req1 || m_acc1) begin
        req1 = ($urandom_range(0, 2) != 0);
        we1 = 1'($urandom_range(0, 1));
        addr1 = AW'($urandom_range(0, 31));
        wdata1 = {$urandom, $urandom};
      end
      saveReq = ($urandom_range(0, 29) == 0);
      if (!busy) done_after = $urandom_range(0, 10);
      step();
    end
    req0 = 0; req1 = 0; saveReq = 0;
    repeat (20) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
